// File: rtl/crc_sched_pkg.sv
// Shared types and defaults for the CRC job scheduler.
// The FSM state enum and kernel-facing parameter defaults live here.
package crc_sched_pkg;

  localparam int unsigned CrcWDefault       = 24;
  localparam int unsigned TimeoutCycDefault = 4096;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitDone,
    StResp,
    StHalt
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from the requester after last_owner, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned OWN_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] pick,
  output logic               found
);

  logic [OWN_W-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    // Offsets 1..NUM_REQ visit every requester once, ending at last_owner itself.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = OWN_W'((32'(last_owner) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crc_job_scheduler.sv
// Shares one crc24a HLS kernel (ap_ctrl_hs) among NUM_REQ requesters with
// round-robin arbitration, a per-job timeout and a sticky halt on timeout.
module crc_job_scheduler
  import crc_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned CRC_W       = CrcWDefault,
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] resp_valid,
  output logic [CRC_W-1:0]   resp_crc,
  output logic               resp_timeout,
  output logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic [CRC_W-1:0]   ap_return,
  output logic               halted,
  output logic [15:0]        job_count
);

  localparam int unsigned OwnW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TcW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e              state;
  logic [OwnW-1:0]     last_owner;
  logic [OwnW-1:0]     owner;
  logic [TcW-1:0]      tcnt;
  logic [NUM_REQ-1:0]  pick;
  logic                found;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OwnW)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner),
    .pick       (pick),
    .found      (found)
  );

  // Index of the current owner, derived from the one-hot grant register.
  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) owner = OwnW'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= StIdle;
      grant        <= '0;
      resp_valid   <= '0;
      resp_crc     <= '0;
      resp_timeout <= 1'b0;
      ap_start     <= 1'b0;
      halted       <= 1'b0;
      job_count    <= '0;
      last_owner   <= OwnW'(NUM_REQ - 1);
      tcnt         <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (found) begin
            grant    <= pick;
            ap_start <= 1'b1;
            state    <= StStart;
          end
        end

        StStart: begin
          if (ap_ready) begin
            ap_start <= 1'b0;
            tcnt     <= '0;
            // A kernel that finishes in the accepting cycle skips WAIT_DONE.
            if (ap_done) begin
              resp_crc     <= ap_return;
              resp_timeout <= 1'b0;
              resp_valid   <= grant;
              state        <= StResp;
            end else begin
              state <= StWaitDone;
            end
          end
        end

        StWaitDone: begin
          if (ap_done) begin
            resp_crc     <= ap_return;
            resp_timeout <= 1'b0;
            resp_valid   <= grant;
            state        <= StResp;
          end else if (tcnt == TcW'(TIMEOUT_CYC - 1)) begin
            resp_crc     <= '0;
            resp_timeout <= 1'b1;
            resp_valid   <= grant;
            state        <= StResp;
          end else begin
            tcnt <= tcnt + TcW'(1);
          end
        end

        StResp: begin
          // resp_timeout doubles as the job's timeout flag during this cycle.
          resp_valid   <= '0;
          resp_timeout <= 1'b0;
          grant        <= '0;
          last_owner   <= owner;
          if (resp_timeout) begin
            halted <= 1'b1;
            state  <= StHalt;
          end else begin
            job_count <= job_count + 16'd1;
            state     <= StIdle;
          end
        end

        StHalt: begin
          grant    <= '0;
          ap_start <= 1'b0;
          halted   <= 1'b1;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_job_scheduler.sv
// Scoreboard bench for crc_job_scheduler driving a behavioural ap_ctrl_hs kernel.
module tb_crc_job_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned CW = 24;
  localparam int unsigned TO = 16;
  localparam logic [CW-1:0] Junk = 24'hDEAD55;

  logic          clock = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [NR-1:0] grant;
  logic [NR-1:0] resp_valid;
  logic [CW-1:0] resp_crc;
  logic          resp_timeout;
  logic          ap_start;
  logic          ap_ready;
  logic          ap_done;
  logic [CW-1:0] ap_return;
  logic          halted;
  logic [15:0]   job_count;

  typedef struct packed {
    logic [NR-1:0] owner;
    logic [CW-1:0] crc;
    logic          tmo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  crc_job_scheduler #(
    .NUM_REQ     (NR),
    .CRC_W       (CW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .grant        (grant),
    .resp_valid   (resp_valid),
    .resp_crc     (resp_crc),
    .resp_timeout (resp_timeout),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_return    (ap_return),
    .halted       (halted),
    .job_count    (job_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Every response pulse must match the oldest expected job.
  always @(negedge clock) begin
    if (!reset && resp_valid != '0) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_owner", 32'(resp_valid), 32'(mon_e.owner));
        check("sb_crc", 32'(resp_crc), 32'(mon_e.crc));
        check("sb_tmo", 32'(resp_timeout), 32'(mon_e.tmo));
      end
    end
  end

  // Caller leaves the DUT in IDLE with req set; returns with the DUT back in IDLE.
  task automatic do_job(input logic [NR-1:0] exp_g, input int rdy, input int dly,
                        input logic [CW-1:0] ret, input bit drop);
    exp_t e;
    tick();
    check("grant", 32'(grant), 32'(exp_g));
    check("ap_start", 32'(ap_start), 32'd1);
    if (drop) req = '0;
    e.owner = exp_g;
    e.crc   = ret;
    e.tmo   = 1'b0;
    sb.push_back(e);
    repeat (rdy) begin
      tick();
      check("start_hold", 32'(ap_start), 32'd1);
    end
    ap_ready = 1'b1;
    if (dly == 0) begin
      ap_done   = 1'b1;
      ap_return = ret;
    end
    tick();
    ap_ready  = 1'b0;
    ap_done   = 1'b0;
    ap_return = Junk;
    if (dly > 0) begin
      check("wait_nostart", 32'(ap_start), 32'd0);
      check("wait_novalid", 32'(resp_valid), 32'd0);
      repeat (dly - 1) tick();
      ap_done   = 1'b1;
      ap_return = ret;
      tick();
      ap_done   = 1'b0;
      ap_return = Junk;
    end
    check("resp_lat", 32'(resp_valid), 32'(exp_g));
    check("resp_grant", 32'(grant), 32'(exp_g));
    check("resp_crc", 32'(resp_crc), 32'(ret));
    tick();
    check("idle_grant", 32'(grant), 32'd0);
    check("idle_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int w;
    logic [NR-1:0] order [5];
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;

    reset     = 1'b1;
    req       = '0;
    ap_ready  = 1'b0;
    ap_done   = 1'b0;
    ap_return = '0;
    repeat (2) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_crc", 32'(resp_crc), 32'd0);
    check("rst_tmo", 32'(resp_timeout), 32'd0);
    check("rst_start", 32'(ap_start), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", 32'(job_count), 32'd0);
    reset = 1'b0;
    tick();

    // Single job, ready after 2 cycles, done 10 cycles later.
    req = 4'b0001;
    do_job(4'b0001, 2, 10, 24'hABCDEF, 1'b0);
    req = '0;
    check("count_1", 32'(job_count), 32'd1);

    // Stray kernel handshakes in IDLE are ignored.
    ap_ready = 1'b1;
    ap_done  = 1'b1;
    tick();
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    tick();
    check("idle_ign_start", 32'(ap_start), 32'd0);
    check("idle_ign_grant", 32'(grant), 32'd0);

    // Round robin from a fresh reset with all requesters active.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_job(order[i], i % 3, 1 + i, 24'h010203 * (i + 1), 1'b0);
    end
    req = '0;
    check("count_5", 32'(job_count), 32'd5);

    // Ready and done together in the first START cycle; requester drops req.
    req = 4'b0100;
    do_job(4'b0100, 0, 0, 24'h000123, 1'b1);
    check("count_6", 32'(job_count), 32'd6);

    // Reset in WAIT_DONE kills the job without a response.
    req = 4'b0100;
    tick();
    check("mid_grant", 32'(grant), 32'(4'b0100));
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    req      = '0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_start", 32'(ap_start), 32'd0);
    check("mid_rst_count", 32'(job_count), 32'd0);
    check("mid_rst_crc", 32'(resp_crc), 32'd0);
    ap_done   = 1'b1;
    ap_return = 24'h777777;
    tick();
    ap_done = 1'b0;
    req = 4'b0010;
    do_job(4'b0010, 1, 3, 24'h5A5A5A, 1'b0);
    req = '0;
    check("count_post_rst", 32'(job_count), 32'd1);

    // Counter wrap: preset to 0xFFFF, one more completion returns it to 0.
    force dut.job_count = 16'hFFFF;
    tick();
    release dut.job_count;
    req = 4'b0001;
    do_job(4'b0001, 0, 2, 24'h00BEEF, 1'b0);
    req = '0;
    check("count_wrap", 32'(job_count), 32'd0);

    // Kernel never finishes: timeout response, then sticky halt.
    req = 4'b1000;
    tick();
    check("tmo_grant", 32'(grant), 32'(4'b1000));
    mon_e.owner = 4'b1000;
    mon_e.crc   = '0;
    mon_e.tmo   = 1'b1;
    sb.push_back(mon_e);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    w = 0;
    while (resp_valid == '0 && w < 40) begin
      tick();
      w++;
    end
    check("tmo_seen", 32'(resp_valid), 32'(4'b1000));
    check("tmo_window", 32'(w >= 15 && w <= 17), 32'd1);
    check("tmo_flag", 32'(resp_timeout), 32'd1);
    check("tmo_crc", 32'(resp_crc), 32'd0);
    tick();
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_grant", 32'(grant), 32'd0);
    req      = 4'b1111;
    ap_ready = 1'b1;
    ap_done  = 1'b1;
    repeat (5) tick();
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    tick();
    check("halt_hold", 32'(halted), 32'd1);
    check("halt_req_ign", 32'(grant), 32'd0);
    check("halt_nostart", 32'(ap_start), 32'd0);
    check("halt_count", 32'(job_count), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, failed %0d", n_fail);
    $fatal(1);
  end

endmodule
